// File: rtl/frac_div_pkg.sv
// Shared defaults and config validation for the fractional clock-enable divider.
package frac_div_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned M_RST_DEF = 7;
  localparam int unsigned N_RST_DEF = 3;

  // A ratio is usable only when 0 < n <= m; callers zero-extend to 32 bits.
  function automatic logic cfg_valid(input logic [31:0] m, input logic [31:0] n);
    return (n != 32'd0) && (n <= m);
  endfunction

endpackage

// File: rtl/frac_div_acc.sv
// Bresenham phase accumulator producing the clk_en pulse and the clock-shaped output.
module frac_div_acc
  import frac_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] n,
  output logic             clk_en,
  output logic             clk_out
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]   sum;
  logic             hit;
  logic             out_nxt;

  // One extra bit keeps acc + n and 2*acc_nxt free of overflow.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, n};
    hit     = (sum >= {1'b0, m});
    acc_nxt = hit ? WIDTH'(sum - {1'b0, m}) : WIDTH'(sum);
    out_nxt = ({acc_nxt, 1'b0} < {1'b0, m});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      clk_en  <= 1'b0;
      clk_out <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      clk_en <= 1'b0;
    end else if (step) begin
      acc     <= acc_nxt;
      clk_en  <= hit;
      clk_out <= out_nxt;
    end else begin
      clk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/frac_clk_div.sv
// Runtime-programmable fractional clock-enable generator: N evenly spread pulses per M-cycle frame.
module frac_clk_div
  import frac_div_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned M_RST = M_RST_DEF,
  parameter int unsigned N_RST = N_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_m,
  input  logic [WIDTH-1:0] cfg_n,
  output logic             clk_en,
  output logic             clk_out,
  output logic             frame_start,
  output logic             cfg_err
);

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] frame_cnt;
  logic             load_ok;
  logic             step;

  // A valid load takes priority over accumulation in the same cycle.
  assign load_ok = cfg_load && cfg_valid(32'(cfg_m), 32'(cfg_n));
  assign step    = enable && !load_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg       <= WIDTH'(M_RST);
      n_reg       <= WIDTH'(N_RST);
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (load_ok) begin
        m_reg     <= cfg_m;
        n_reg     <= cfg_n;
        frame_cnt <= '0;
        cfg_err   <= 1'b0;
      end else if (cfg_load) begin
        cfg_err <= 1'b1;
      end
      frame_start <= step && (frame_cnt == '0);
      if (step) begin
        frame_cnt <= (frame_cnt == m_reg - WIDTH'(1)) ? '0 : frame_cnt + WIDTH'(1);
      end
    end
  end

  frac_div_acc #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (load_ok),
    .step    (step),
    .m       (m_reg),
    .n       (n_reg),
    .clk_en  (clk_en),
    .clk_out (clk_out)
  );

endmodule

// File: doc/frac_clk_div.md
# frac_clk_div

Runtime-programmable fractional clock-enable generator: produces exactly N enable pulses, evenly spread, in every frame of M input clock cycles (N ≤ M). It uses a Bresenham-style phase accumulator. It also provides a near-50%-duty registered clock-shaped output and a frame marker for checking. It generalises the fixed-parameter integer, odd and M/N dividers in this library. Ratios become width-parametrised and loadable at run time, with config validation and an enable gate.

## Interface
- WIDTH, 8, bit width of M, N, accumulator and frame counter
- M_RST, 7, M value after reset
- N_RST, 3, N value after reset
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  advance the accumulator this cycle
- cfg_load  in  1  load cfg_m/cfg_n this cycle
- cfg_m  in  WIDTH  frame length M
- cfg_n  in  WIDTH  pulses per frame N
- clk_en  out  1  one-cycle enable pulse
- clk_out  out  1  registered divided clock
- frame_start  out  1  marks first cycle of each M-cycle frame
- cfg_err  out  1  last load rejected (sticky until next valid load)

## Operation
- Reset values: m_reg=M_RST, n_reg=N_RST, acc=0, frame_cnt=0, clk_en=0, clk_out=0, frame_start=0, cfg_err=0.
- A load is valid iff 0 < cfg_n ≤ cfg_m.
- Valid load:
  - m_reg/n_reg updated; acc=0; frame_cnt=0; cfg_err=0.
  - clk_en=0 and frame_start=0 next cycle; clk_out unchanged.
- Invalid load:
  - m_reg/n_reg/acc/frame_cnt retained; cfg_err=1.
  - The enabled cycle, if any, is still processed normally.
- cfg_load with enable in the same cycle: a valid load wins and no accumulation happens that cycle.
- Enabled cycle k (k=1,2,... counted from reset or a valid load):
  - sum = acc + n_reg, computed at WIDTH+1 bits, no overflow.
  - If sum ≥ m_reg: acc ← sum − m_reg and clk_en ← 1. Otherwise acc ← sum and clk_en ← 0.
  - clk_out ← (2·acc_new < m_reg), compared at WIDTH+1 bits.
  - frame_start ← (frame_cnt == 0).
  - frame_cnt ← (frame_cnt == m_reg−1) ? 0 : frame_cnt+1.
- Equivalent: clk_en for cycle k is 1 iff ⌊kN/M⌋ > ⌊(k−1)N/M⌋. Each frame has exactly N pulses, the last at k ≡ 0 mod M, and acc=0 at every frame end.
- enable=0 (no valid load): acc and frame_cnt hold; clk_en=0 and frame_start=0; clk_out holds.
- N == M: clk_en=1 on every enabled cycle; clk_out stays 1.
- 2N ≤ M: each clk_out rising edge coincides with a clk_en pulse.
- 2N > M: clk_out may merge pulses; consumers use clk_en only.
- rst mid-operation: all state returns to reset values on that edge; config reverts to M_RST/N_RST.

## Timing
- Latency: one cycle. Outputs for enabled cycle k are visible during cycle k+1.
- frame_start pulses are exactly M enabled cycles apart; the first appears one cycle after the first enabled cycle following a load or reset.
- Config change takes effect on the first enabled cycle after the load edge.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package frac_div_pkg holds:
  - the default WIDTH constant and the M_RST/N_RST defaults;
  - a cfg-validity function (0 < n ≤ m).
- One sub-module, frac_div_acc: accumulator, compare/subtract and clk_en/clk_out generation. The top level holds the config registers, validation, frame counter and cfg_err.

## Test plan
- Reset, then enable held high, M=7, N=3 → clk_en pattern per frame k1..k7 = 0,0,1,0,1,0,1. clk_out = 1,0,1,0,1,0,1. frame_start every 7 cycles.
- Load M=10, N=10 → clk_en constantly 1 and clk_out constantly 1 after the first enabled cycle. Then load M=255, N=1 → exactly one pulse per 255 cycles, at k=255.
- Load N=0 (M=5), then N=6 (M=5) → cfg_err=1 both times; output pattern continues with the previous 7/3 config. A later valid load clears cfg_err.
- Toggle enable randomly at 50% with M=9, N=4 → over 900 enabled cycles exactly 400 clk_en. Each 9-enabled-cycle frame has 4 pulses.
- cfg_load with enable in the same cycle, mid-frame → next-cycle clk_en=0 and frame_start=0. The new frame starts at k=1 on the following enabled cycle.
- Assert rst mid-frame with M=13, N=5 loaded → all outputs 0 next cycle. The pattern restarts from k=1 using 7/3.
